instr_fetch_unit: RTL and testbench

//  Fetch stage between the program-counter register and decode. Takes the current PC,

---
 rtl/instr_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues single-outstanding word reads to instruction
// memory, buffers returned words with their PC in a small FIFO for decode, and
// produces the next-PC value (sequential +4 or redirect target).
module instr_fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int QDEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] pc_next,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              dec_ready
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [DATA_W-1:0] data_mem_q [QDEPTH];
    logic [DATA_W-1:0] data_mem_d [QDEPTH];
    logic [ADDR_W-1:0] pc_mem_q [QDEPTH];
    logic [ADDR_W-1:0] pc_mem_d [QDEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic pop_s;
    logic push_s;
    logic slots_free_s;
    logic req_s;
    logic accept_s;

    // Decode consumes the head this cycle; a slot freed by that pop may be reused
    assign pop_s        = (count_q != '0) && dec_ready;
    assign slots_free_s = (count_q < CNT_W'(QDEPTH)) || pop_s;
    assign accept_s     = req_s && imem_gnt;

    assign imem_req    = req_s;
    assign imem_addr   = pc_in;
    assign instr_valid = (count_q != '0);
    assign instr       = data_mem_q[head_q];
    assign instr_pc    = pc_mem_q[head_q];

    // Fetch FSM: request gating, response acceptance and stale-response flushing
    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        req_s    = 1'b0;
        push_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_s = slots_free_s && !redirect && !reset;
                if (req_s && imem_gnt) begin
                    state_d  = ST_WAIT;
                    req_pc_d = pc_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    // A redirect in the same cycle makes this response stale
                    push_s  = !redirect;
                    state_d = ST_IDLE;
                end else if (redirect) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_FLUSH: begin
                if (imem_rvalid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next PC: redirect wins, otherwise advance by one word when a fetch is accepted
    always_comb begin
        pc_next = pc_in;
        if (reset) begin
            pc_next = pc_in;
        end else if (redirect) begin
            pc_next = redirect_target;
        end else if (accept_s) begin
            pc_next = pc_in + ADDR_W'(4);
        end else begin
            pc_next = pc_in;
        end
    end

    // Fetch buffer bookkeeping: redirect empties it, otherwise push/pop update pointers
    always_comb begin
        data_mem_d = data_mem_q;
        pc_mem_d   = pc_mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_s) begin
                data_mem_d[tail_q] = imem_rdata;
                pc_mem_d[tail_q]   = req_pc_q;
                tail_d             = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State and buffer registers with synchronous reset dropping all in-flight state
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            req_pc_q   <= '0;
            data_mem_q <= '{default: '0};
            pc_mem_q   <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            data_mem_q <= data_mem_d;
            pc_mem_q   <= pc_mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios followed by randomized
// traffic, with a queue-based reference of the instruction stream decode
// should see and a separate monitor that pops and compares on each dequeue.
module tb_instr_fetch_unit;

    localparam int QD = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        dec_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    // Reference state: expected decode stream plus memory-side bookkeeping
    entry_t      exp_q[$];
    bit          mon_en      = 1'b0;
    bit          outstanding = 1'b0;
    bit          stale       = 1'b0;
    logic [31:0] pend_pc     = 32'd0;
    logic [31:0] model_pc    = 32'h0000_0100;
    int          wait_cnt    = 0;
    int          next_wait   = -1;
    bit          data_ovr    = 1'b0;
    logic [31:0] data_val    = 32'd0;
    int          acc_count   = 0;

    instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .QDEPTH(QD)) dut (
        .clock           (clock),
        .reset           (reset),
        .pc_in           (pc_in),
        .pc_next         (pc_next),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .dec_ready       (dec_ready)
    );

    always #5 clock = ~clock;

    function automatic void check_word(string name, logic [31:0] act, logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void check_bit(string name, logic act, logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: each cycle compare head validity, and on a dequeue pop the scoreboard
    always @(negedge clock) begin
        entry_t e;
        #2;
        if (mon_en) begin
            check_bit("instr_valid", instr_valid, exp_q.size() != 0);
            if (instr_valid === 1'b1 && dec_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL pop_empty: got instr %h pc %h expected no entry (t=%0t)",
                             instr, instr_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    check_word("instr", instr, e.data);
                    check_word("instr_pc", instr_pc, e.pc);
                end
            end
        end
    end

    // One clock of stimulus; the reference decides request, next PC and buffer contents
    task automatic step(input bit redir, input logic [31:0] tgt, input bit gnt,
                        input bit rdy, input bit stray);
        bit          rv;
        bit          exp_req;
        bit          acc;
        logic [31:0] d;
        logic [31:0] exp_pcn;
        entry_t      e;
        @(negedge clock);
        rv = stray || (outstanding && wait_cnt == 0);
        d  = $urandom;
        if (rv && data_ovr) begin
            d        = data_val;
            data_ovr = 1'b0;
        end
        pc_in           = model_pc;
        redirect        = redir;
        redirect_target = tgt;
        imem_gnt        = gnt;
        dec_ready       = rdy;
        imem_rvalid     = rv;
        imem_rdata      = d;
        #3;
        exp_req = !outstanding && !redir && (exp_q.size() < QD);
        check_bit("imem_req", imem_req, exp_req);
        if (exp_req) check_word("imem_addr", imem_addr, model_pc);
        acc     = exp_req && gnt;
        exp_pcn = redir ? tgt : (acc ? model_pc + 32'd4 : model_pc);
        check_word("pc_next", pc_next, exp_pcn);
        if (imem_req === 1'b1 && gnt) acc_count++;
        if (outstanding) begin
            if (rv) begin
                if (!stale && !redir) begin
                    e.pc   = pend_pc;
                    e.data = d;
                    exp_q.push_back(e);
                end
                outstanding = 1'b0;
                stale       = 1'b0;
            end else begin
                if (redir) stale = 1'b1;
                if (wait_cnt > 0) wait_cnt--;
            end
        end
        if (redir) exp_q.delete();
        if (acc) begin
            outstanding = 1'b1;
            stale       = 1'b0;
            pend_pc     = model_pc;
            wait_cnt    = (next_wait >= 0) ? next_wait : int'($urandom_range(0, 2));
            next_wait   = -1;
        end
        model_pc = exp_pcn;
    endtask

    // Hold reset for n cycles with gnt high, then release and check the cleared head
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            reset       = 1'b1;
            mon_en      = 1'b0;
            imem_gnt    = 1'b1;
            imem_rvalid = 1'b0;
            redirect    = 1'b0;
            dec_ready   = 1'b0;
            pc_in       = model_pc;
            exp_q.delete();
            outstanding = 1'b0;
            stale       = 1'b0;
            wait_cnt    = 0;
            #3;
            check_bit("rst_imem_req", imem_req, 1'b0);
            check_word("rst_pc_next", pc_next, model_pc);
            if (i > 0) check_bit("rst_instr_valid", instr_valid, 1'b0);
        end
        @(negedge clock);
        reset    = 1'b0;
        imem_gnt = 1'b0;
        mon_en   = 1'b1;
        #3;
        check_word("rst_instr", instr, 32'd0);
        check_word("rst_instr_pc", instr_pc, 32'd0);
    endtask

    initial begin
        bit          r_redir;
        bit          r_gnt;
        bit          r_rdy;
        logic [31:0] r_tgt;
        int          start_acc;

        reset           = 1'b1;
        pc_in           = model_pc;
        redirect        = 1'b0;
        redirect_target = 32'd0;
        imem_gnt        = 1'b1;
        imem_rvalid     = 1'b0;
        imem_rdata      = 32'd0;
        dec_ready       = 1'b0;

        // Reset held three cycles with grant asserted
        do_reset(3);

        // Single fetch at 0x100 with one-cycle memory latency
        next_wait = 0;
        data_ovr  = 1'b1;
        data_val  = 32'hDEAD_BEEF;
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // Decode stalled: buffer fills after QD requests, then one slot frees one request
        start_acc = acc_count;
        for (int i = 0; i < 8; i++) begin
            next_wait = 0;
            step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        end
        check_word("full_req_count", 32'(acc_count - start_acc), 32'd2);
        start_acc = acc_count;
        next_wait = 0;
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        check_word("refill_req_count", 32'(acc_count - start_acc), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // Redirect while waiting on 0x108: late response discarded, refetch from 0x200
        step(1'b1, 32'h0000_0108, 1'b0, 1'b1, 1'b0);
        next_wait = 3;
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        data_ovr = 1'b1;
        data_val = 32'h1111_1111;
        step(1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

        // Redirect coincident with the response, then redirect with grant while idle
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        next_wait = 0;
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0300, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0400, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);

        // PC wrap at the top of the address space, then reset while a request is in flight
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
        next_wait = 2;
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        check_word("wrap_pc", model_pc, 32'h0000_0000);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        do_reset(3);
        data_ovr = 1'b1;
        data_val = 32'h1111_1111;
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic with periodic decode stalls and an occasional reset
        for (int c = 0; c < 3000; c++) begin
            r_redir = ($urandom_range(0, 11) == 0);
            r_tgt   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            r_gnt   = ($urandom_range(0, 2) != 0);
            r_rdy   = ((c % 200) < 30) ? 1'b0 : ($urandom_range(0, 1) == 1);
            if (c == 1500) do_reset(2);
            step(r_redir, r_tgt, r_gnt, r_rdy, 1'b0);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
